gmii_tx_framer: RTL and testbench
=================================

# gmii_tx_framer

Transmit-side MAC framer that turns a byte-wide packet stream into a complete GMII transmit frame: preamble, SFD, payload, optional zero padding, CRC-32 FCS and inter-frame gap. It sits in the GTX_CLK domain directly upstream of the RGMII converter and drives that converter's GMII_TXD_FROM_CORE, GMII_TX_EN_FROM_CORE and GMII_TX_ER_FROM_CORE inputs. Upstream it is fed by the packet buffer through a valid/ready stream.

## Interface
- IFG_BYTES, 12: minimum idle cycles with TX_EN low between frames (≥1).
- MIN_PAYLOAD, 60: minimum bytes before FCS when padding is compiled in.
- GTX_CLK  in  1  transmit clock, 125 MHz at 1000M. Single clock, all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  payload byte (DA first, no preamble or FCS).
- in_valid  in  1  in_data/in_sop/in_eop/in_err are valid.
- in_sop  in  1  first byte of frame.
- in_eop  in  1  last byte of frame.
- in_err  in  1  byte is corrupt; transmit with TX_ER.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- GMII_TXD  out  8  to GMII_TXD_FROM_CORE.
- GMII_TX_EN  out  1  to GMII_TX_EN_FROM_CORE.
- GMII_TX_ER  out  1  to GMII_TX_ER_FROM_CORE.
- frame_done  out  1  one-cycle pulse with the last FCS byte.
- underrun  out  1  one-cycle pulse when the frame is aborted.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG.
- IDLE: in_ready = in_valid & !in_sop, so stray non-SOP bytes are accepted and discarded. in_valid & in_sop → PRE. The SOP byte is not consumed.
- PRE: 7 cycles of 0x55. SFD: 1 cycle of 0xD5. Then → DATA.
- DATA: in_ready = 1. Each accepted byte goes out and updates the CRC and an 11-bit byte count that saturates at 2047.
  - Accepted byte with in_eop: → PAD if count < MIN_PAYLOAD and padding is enabled, else → FCS.
  - in_valid low in DATA (underrun): emit 0x00 with TX_EN=1 and TX_ER=1 for one cycle, pulse underrun, → DRAIN.
  - in_sop on a non-first DATA byte is ignored.
- PAD: emit 0x00 through the CRC until count = MIN_PAYLOAD, then → FCS.
- FCS: 4 bytes, ~CRC[7:0] first, up to ~CRC[31:24] last. frame_done pulses with the last byte. → IFG.
- DRAIN: TX_EN low, in_ready = 1, discard bytes through in_eop, then → IFG.
- IFG: TX_EN low for IFG_BYTES cycles, then → IDLE.
- CRC: IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, LSB-first byte update, output complemented.
- GMII_TX_ER = in_err of the transmitted byte in DATA, 1 on the underrun cycle, else 0.
- Outside PRE/SFD/DATA/PAD/FCS and the underrun cycle: GMII_TXD = 0x00, TX_EN = 0, TX_ER = 0.

## Timing
- All GMII outputs, frame_done and underrun are registered. in_ready is combinational from state and in_valid/in_sop.
- Reset value of all registered outputs: 0. State = IDLE, CRC = 0xFFFFFFFF, counters = 0.
- Latency:
  - SOP sampled in IDLE at edge N: first 0x55 on GMII_TXD after edge N+1.
  - SFD after edge N+8.
  - Byte accepted at edge M appears after edge M+1.
- Wire length = 8 + max(L, MIN_PAYLOAD or L) + 4 cycles of TX_EN high, followed by ≥ IFG_BYTES cycles of TX_EN low.
- in_valid & in_sop during IFG is held off (in_ready = 0) until IDLE.
- Reset mid-frame: outputs drop to 0 asynchronously and the frame is truncated. No IFG is enforced after reset release, so a frame may start on the first edge.
- Back-to-back frames with in_valid held high: next preamble starts exactly IFG_BYTES + 1 cycles after the last FCS byte.

## Configuration
- GMII_TX_PAD_EN defined: frames shorter than MIN_PAYLOAD are zero-padded before the FCS.
- GMII_TX_PAD_EN undefined: the PAD state is removed and short frames are sent unpadded (FCS over payload only).

## Test plan
- Padding off: 9-byte frame "123456789" (0x31..0x39) with in_valid held high → 7×0x55, 0xD5, 0x31..0x39, FCS 0x26 0x39 0xF4 0xCB. TX_EN high for exactly 21 cycles; frame_done pulses with 0xCB.
- Padding on: same 9-byte frame → 51 bytes of 0x00 after 0x39, then the FCS of the 60-byte padded frame (check against the reference model). TX_EN high for 72 cycles.
- Back-to-back 64-byte frames, IFG_BYTES=12 → exactly 12 cycles of TX_EN low between the last FCS byte and the next 0x55. in_ready = 0 throughout the IFG.
- in_valid dropped for 1 cycle after payload byte 20 of 100 → one cycle with TX_EN=1, TX_ER=1, TXD=0x00; underrun pulse. Remaining bytes are discarded through eop; TX_EN stays low until the next SOP after the IFG.
- in_err on payload byte 5 → TX_ER high only on the cycle that byte is on GMII_TXD. The FCS is still sent.
- reset_n low during payload byte 30 → TX_EN, TX_ER and TXD go to 0 immediately. After release, a new SOP gives a 0x55 two edges later.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: turns a byte-wide valid/ready packet stream into a GMII transmit frame
// (preamble, SFD, payload, optional zero pad, CRC-32 FCS, inter-frame gap).
// Optional feature macro: GMII_TX_PAD_EN -- when defined, frames shorter than MIN_PAYLOAD
// bytes are zero-padded before the FCS; when undefined, short frames go out unpadded.
module gmii_tx_framer #(
    parameter int unsigned IFG_BYTES   = 12,
    parameter int unsigned MIN_PAYLOAD = 60
) (
    input  logic       GTX_CLK,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic       in_eop,
    input  logic       in_err,
    output logic       in_ready,
    output logic [7:0] GMII_TXD,
    output logic       GMII_TX_EN,
    output logic       GMII_TX_ER,
    output logic       frame_done,
    output logic       underrun
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BCNT_W = 11;

    localparam logic [31:0]       CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]       CRC_POLY = 32'hEDB8_8320;
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(6);
    localparam logic [CNT_W-1:0]  FCS_LAST = CNT_W'(3);
    // The IDLE cycle that samples the next SOP supplies the last idle cycle of the gap,
    // so the IFG state itself only needs IFG_BYTES-1 cycles.
    localparam logic [CNT_W-1:0]  IFG_LAST = CNT_W'((IFG_BYTES > 1) ? (IFG_BYTES - 2) : 32'd0);
    localparam bit                IFG_NEEDED = (IFG_BYTES > 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX = '1;
`ifdef GMII_TX_PAD_EN
    localparam logic [BCNT_W-1:0] MIN_CNT  = BCNT_W'(MIN_PAYLOAD);
`endif

    // Elaboration-time parameter sanity.
    if (IFG_BYTES == 0) begin : g_bad_ifg
        $error("gmii_tx_framer: IFG_BYTES must be at least 1");
    end
    if (MIN_PAYLOAD > 2047) begin : g_bad_min
        $error("gmii_tx_framer: MIN_PAYLOAD must fit the 11-bit byte counter");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        SFD   = 3'd2,
        DATA  = 3'd3,
`ifdef GMII_TX_PAD_EN
        PAD   = 3'd4,
`endif
        FCS   = 3'd5,
        DRAIN = 3'd6,
        IFG   = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d, bcnt_inc;
    logic [31:0]         crc_q, crc_d, fcs_sel;
    logic [7:0]          txd_d;
    logic                tx_en_d, tx_er_d, done_d, underrun_d;

    // One LSB-first byte update of the reflected CRC-32.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    // Saturating payload byte count and complemented CRC for the FCS bytes.
    assign bcnt_inc = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + BCNT_W'(1);
    assign fcs_sel  = ~crc_q;

    // Next-state, next-output and handshake logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        crc_d      = crc_q;
        txd_d      = 8'h00;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        in_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                // Stray mid-packet bytes are swallowed; the SOP byte waits for DATA.
                in_ready = in_valid & ~in_sop;
                cnt_d    = '0;
                bcnt_d   = '0;
                crc_d    = CRC_INIT;
                if (in_valid && in_sop) state_d = PRE;
            end

            PRE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = SFD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SFD: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
                cnt_d   = '0;
                state_d = DATA;
            end

            DATA: begin
                in_ready = 1'b1;
                tx_en_d  = 1'b1;
                cnt_d    = '0;
                if (in_valid) begin
                    txd_d   = in_data;
                    tx_er_d = in_err;
                    crc_d   = crc_byte(crc_q, in_data);
                    bcnt_d  = bcnt_inc;
                    if (in_eop) begin
`ifdef GMII_TX_PAD_EN
                        if (bcnt_inc < MIN_CNT) state_d = PAD;
                        else                    state_d = FCS;
`else
                        state_d = FCS;
`endif
                    end
                end else begin
                    // Source ran dry mid-frame: poison the frame and abort.
                    txd_d      = 8'h00;
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                    state_d    = DRAIN;
                end
            end

`ifdef GMII_TX_PAD_EN
            PAD: begin
                txd_d   = 8'h00;
                tx_en_d = 1'b1;
                cnt_d   = '0;
                crc_d   = crc_byte(crc_q, 8'h00);
                bcnt_d  = bcnt_inc;
                if (bcnt_inc >= MIN_CNT) state_d = FCS;
            end
`endif

            FCS: begin
                txd_d   = fcs_sel[{cnt_q[1:0], 3'b000} +: 8];
                tx_en_d = 1'b1;
                if (cnt_q == FCS_LAST) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (IFG_NEEDED) state_d = IFG;
                    else            state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DRAIN: begin
                in_ready = 1'b1;
                cnt_d    = '0;
                if (in_valid && in_eop) begin
                    if (IFG_NEEDED) state_d = IFG;
                    else            state_d = IDLE;
                end
            end

            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered GMII outputs.
    always_ff @(posedge GTX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            crc_q      <= CRC_INIT;
            GMII_TXD   <= 8'h00;
            GMII_TX_EN <= 1'b0;
            GMII_TX_ER <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcnt_q     <= bcnt_d;
            crc_q      <= crc_d;
            GMII_TXD   <= txd_d;
            GMII_TX_EN <= tx_en_d;
            GMII_TX_ER <= tx_er_d;
            frame_done <= done_d;
            underrun   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: table of known-CRC frames plus hand-written
// sequences for back-to-back IFG, underrun, TX_ER and mid-frame reset.
`timescale 1ns/1ps
module tb_gmii_tx_framer;

    localparam int IFG_BYTES   = 12;
    localparam int MIN_PAYLOAD = 60;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic       in_eop = 1'b0;
    logic       in_err = 1'b0;
    logic       in_ready;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_er;
    logic       frame_done;
    logic       underrun;

    gmii_tx_framer #(
        .IFG_BYTES  (IFG_BYTES),
        .MIN_PAYLOAD(MIN_PAYLOAD)
    ) dut (
        .GTX_CLK    (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_err     (in_err),
        .in_ready   (in_ready),
        .GMII_TXD   (txd),
        .GMII_TX_EN (tx_en),
        .GMII_TX_ER (tx_er),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] pay [0:255];
    int         plen;

    // Wire monitor, sampled mid-low-phase.
    logic [7:0] w_d[$];
    bit         w_er[$];
    bit         w_done[$];
    int         gaps[$];
    int         und_cnt = 0, und_idx = -1, frames = 0, low_run = 0, low_ready = 0;
    int         first_en_cyc = -1;
    bit         had_frame = 1'b0, prev_en = 1'b0;

    always @(negedge clk) begin
        #2;
        if (underrun) begin
            und_cnt++;
            und_idx = w_d.size();
        end
        if (tx_en) begin
            if (!prev_en) begin
                if (had_frame) gaps.push_back(low_run);
                first_en_cyc = cyc;
            end
            w_d.push_back(txd);
            w_er.push_back(tx_er);
            w_done.push_back(frame_done);
            low_run = 0;
        end else begin
            if (prev_en) begin
                frames++;
                had_frame = 1'b1;
            end
            low_run++;
            if (in_ready) low_ready++;
        end
        prev_en = tx_en;
    end

    typedef struct {
        string       txt;
        int          err_idx;
        int          exp_len;
        logic [31:0] exp_fcs;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        w_d.delete();
        w_er.delete();
        w_done.delete();
        gaps.delete();
        und_cnt = 0;
        und_idx = -1;
        low_ready = 0;
        had_frame = 1'b0;
        first_en_cyc = -1;
    endtask

    function automatic int padded(input int len);
`ifdef GMII_TX_PAD_EN
        return (len < MIN_PAYLOAD) ? MIN_PAYLOAD : len;
`else
        return len;
`endif
    endfunction

    // Reference FCS: MSB-first LFSR on the normal polynomial, bits fed LSB-first, then mirrored.
    function automatic logic [31:0] ref_fcs(input int n);
        logic [31:0] r, o;
        logic [7:0]  b;
        logic        fb;
        r = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            b = (i < plen) ? pay[i] : 8'h00;
            for (int k = 0; k < 8; k++) begin
                fb = r[31] ^ b[k];
                r  = {r[30:0], 1'b0};
                if (fb) r = r ^ 32'h04C1_1DB7;
            end
        end
        for (int k = 0; k < 32; k++) o[k] = r[31-k];
        return ~o;
    endfunction

    task automatic load_str(input string s);
        plen = s.len();
        for (int i = 0; i < plen; i++) pay[i] = s[i];
    endtask

    // Present one byte (called at a negedge) and hold it until accepted; returns at a negedge.
    task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input logic er);
        logic r;
        int   t;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_err   = er;
        in_valid = 1'b1;
        r = 1'b0;
        t = 0;
        while (!r && t < 200) begin
            #2;
            r = in_ready;
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        if (!r) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        end
    endtask

    task automatic send_frame(input int len, input int err_idx, input bit hold);
        for (int i = 0; i < len; i++)
            send_byte(pay[i], i == 0, i == len - 1, i == err_idx);
        if (!hold) begin
            in_valid = 1'b0;
            in_sop   = 1'b0;
            in_eop   = 1'b0;
            in_err   = 1'b0;
        end
    endtask

    task automatic wait_frames(input int target, input string nm);
        int t;
        t = 0;
        while (frames < target && t < 400) begin
            @(negedge clk);
            #3;
            t++;
        end
        check({nm, "_frame_end"}, 32'(frames), 32'(target));
        @(negedge clk);
    endtask

    // Check one captured frame starting at wire index base.
    task automatic check_frame(input string nm, input int base, input int len, input int err_idx,
                               input logic [31:0] exp_fcs);
        int          body, n, idx, pre_bad, pay_bad, pad_bad, er_bad, done_n, done_at;
        logic [31:0] fcs;
        bit          exp_er;
        body = padded(len);
        n = 8 + body + 4;
        pre_bad = 0; pay_bad = 0; pad_bad = 0; er_bad = 0; done_n = 0; done_at = -1;
        fcs = 32'h0;
        if (w_d.size() >= base + n) begin
            for (int i = 0; i < n; i++) begin
                idx = base + i;
                if (i < 7)              pre_bad += int'(w_d[idx] != 8'h55);
                else if (i == 7)        pre_bad += int'(w_d[idx] != 8'hD5);
                else if (i < 8 + len)   pay_bad += int'(w_d[idx] != pay[i-8]);
                else if (i < 8 + body)  pad_bad += int'(w_d[idx] != 8'h00);
                exp_er = (err_idx >= 0) && (i == 8 + err_idx);
                er_bad += int'(w_er[idx] != exp_er);
                if (w_done[idx]) begin
                    done_n++;
                    done_at = i;
                end
            end
            fcs = {w_d[base+n-1], w_d[base+n-2], w_d[base+n-3], w_d[base+n-4]};
        end
        check({nm, "_preamble_bad"}, 32'(pre_bad), 32'd0);
        check({nm, "_payload_bad"}, 32'(pay_bad), 32'd0);
`ifdef GMII_TX_PAD_EN
        check({nm, "_pad_bad"}, 32'(pad_bad), 32'd0);
`endif
        check({nm, "_fcs"}, fcs, exp_fcs);
        check({nm, "_tx_er_bad"}, 32'(er_bad), 32'd0);
        check({nm, "_done_count"}, 32'(done_n), 32'd1);
        check({nm, "_done_pos"}, 32'(done_at), 32'(n - 1));
    endtask

    task automatic run_vec(input int v);
        string       nm;
        int          fr0, sop_cyc, exp_len;
        logic [31:0] exp_fcs;
        nm = $sformatf("vec%0d", v);
        load_str(tbl[v].txt);
        clear_mon();
        fr0 = frames;
        sop_cyc = cyc;
        send_frame(plen, tbl[v].err_idx, 1'b0);
        wait_frames(fr0 + 1, nm);
`ifdef GMII_TX_PAD_EN
        exp_len = 8 + padded(plen) + 4;
        exp_fcs = ref_fcs(padded(plen));
`else
        exp_len = tbl[v].exp_len;
        exp_fcs = tbl[v].exp_fcs;
`endif
        check({nm, "_latency"}, 32'(first_en_cyc - sop_cyc), 32'd2);
        check({nm, "_wire_len"}, 32'(w_d.size()), 32'(exp_len));
        check_frame(nm, 0, plen, tbl[v].err_idx, exp_fcs);
        check({nm, "_underrun"}, 32'(und_cnt), 32'd0);
        repeat (IFG_BYTES + 4) @(negedge clk);
    endtask

    initial begin
        int          fr0, sop_cyc, bad;
        logic [31:0] f64;

        tbl[0].txt = "123456789"; tbl[0].err_idx = -1; tbl[0].exp_len = 21; tbl[0].exp_fcs = 32'hCBF4_3926;
        tbl[1].txt = "a";         tbl[1].err_idx = -1; tbl[1].exp_len = 13; tbl[1].exp_fcs = 32'hE8B7_BE43;
        tbl[2].txt = "abc";       tbl[2].err_idx = -1; tbl[2].exp_len = 15; tbl[2].exp_fcs = 32'h3524_41C2;
        tbl[3].txt = "123456789"; tbl[3].err_idx = 4;  tbl[3].exp_len = 21; tbl[3].exp_fcs = 32'hCBF4_3926;
        tbl[4].txt = "The quick brown fox jumps over the lazy dog";
        tbl[4].err_idx = -1; tbl[4].exp_len = 55; tbl[4].exp_fcs = 32'h414F_A339;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'h0);
        check("rst_tx_en", 32'(tx_en), 32'h0);
        check("rst_tx_er", 32'(tx_er), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stray non-SOP byte in IDLE is accepted and dropped.
        clear_mon();
        in_data = 8'hAA; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
        #2;
        check("idle_stray_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_stray_no_tx", 32'(w_d.size()), 32'd0);

        // Table of frames with known CRCs.
        for (int v = 0; v < 5; v++) run_vec(v);

        // Back-to-back 64-byte frames with in_valid held high.
        plen = 64;
        for (int i = 0; i < 64; i++) pay[i] = 8'(i);
        f64 = ref_fcs(64);
        clear_mon();
        fr0 = frames;
        send_frame(64, -1, 1'b1);
        send_frame(64, -1, 1'b0);
        wait_frames(fr0 + 2, "b2b");
        check("b2b_wire_len", 32'(w_d.size()), 32'd152);
        check("b2b_gap_count", 32'(gaps.size()), 32'd1);
        check("b2b_gap_len", 32'((gaps.size() > 0) ? gaps[0] : -1), 32'(IFG_BYTES));
        check("b2b_ready_in_gap", 32'(low_ready), 32'd0);
        check_frame("b2b_f0", 0, 64, -1, f64);
        check_frame("b2b_f1", 76, 64, -1, f64);
        repeat (IFG_BYTES + 4) @(negedge clk);

        // Underrun after payload byte 20 of 100.
        plen = 100;
        for (int i = 0; i < 100; i++) pay[i] = 8'(i + 16);
        clear_mon();
        fr0 = frames;
        for (int i = 0; i < 20; i++) send_byte(pay[i], i == 0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 20; i < 100; i++) send_byte(pay[i], 1'b0, i == 99, 1'b0);
        in_valid = 1'b0; in_eop = 1'b0;
        repeat (40) @(negedge clk);
        bad = 0;
        if (w_d.size() >= 29) begin
            for (int i = 0; i < 20; i++) bad += int'(w_d[8+i] != pay[i]);
            bad += int'(w_d[28] != 8'h00);
            bad += int'(w_er[28] != 1'b1);
            for (int i = 0; i < 28; i++) bad += int'(w_er[i] != 1'b0);
        end
        check("urun_wire_len", 32'(w_d.size()), 32'd29);
        check("urun_bytes_bad", 32'(bad), 32'd0);
        check("urun_pulses", 32'(und_cnt), 32'd1);
        check("urun_pulse_pos", 32'(und_idx), 32'd28);
        check("urun_frames", 32'(frames), 32'(fr0 + 1));
        run_vec(2);

        // Reset asserted while payload byte 30 is on the wire.
        plen = 100;
        for (int i = 0; i < 100; i++) pay[i] = 8'(i * 3 + 1);
        clear_mon();
        for (int i = 0; i < 30; i++) send_byte(pay[i], i == 0, 1'b0, 1'b0);
        check("rst_mid_pre_en", 32'(tx_en), 32'h1);
        check("rst_mid_pre_txd", 32'(txd), 32'(pay[29]));
        #1;
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_mid_txd", 32'(txd), 32'h0);
        check("rst_mid_tx_en", 32'(tx_en), 32'h0);
        check("rst_mid_tx_er", 32'(tx_er), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_mon();
        load_str("abc");
        fr0 = frames;
        sop_cyc = cyc;
        in_data = pay[0]; in_sop = 1'b1; in_eop = 1'b0; in_err = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("rst_rel_edge1_en", 32'(tx_en), 32'h0);
        @(negedge clk);
        check("rst_rel_edge2_txd", 32'(txd), 32'h55);
        check("rst_rel_edge2_en", 32'(tx_en), 32'h1);
        send_frame(plen, -1, 1'b0);
        wait_frames(fr0 + 1, "rst_rel");
        check("rst_rel_latency", 32'(first_en_cyc - sop_cyc), 32'd2);
        check("rst_rel_wire_len", 32'(w_d.size()), 32'(8 + padded(3) + 4));
        check_frame("rst_rel", 0, 3, -1, ref_fcs(padded(3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
